// File: rtl/ternary_argmax_head_if.sv
// Stream interface for ternary_argmax_head.
// Groups the input element stream (in_valid/in_ready/in_data/relu_en), the
// replayed output stream (out_valid/out_ready/out_data/out_last/out_idx) and the
// argmax result (argmax_idx/argmax_valid).
//   master : environment side (drives in_*, relu_en and out_ready)
//   slave  : the argmax head itself
interface ternary_argmax_head_if #(
    parameter int unsigned OUT_LEN   = 8,
    parameter int unsigned BIT_WIDTH = 8
);
    localparam int unsigned IDX_W = $clog2(OUT_LEN);

    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] in_data;
    logic                 relu_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic [IDX_W-1:0]     out_idx;
    logic [IDX_W-1:0]     argmax_idx;
    logic                 argmax_valid;

    modport master (
        output in_valid, in_data, relu_en, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_idx, argmax_idx, argmax_valid
    );

    modport slave (
        input  in_valid, in_data, relu_en, out_ready,
        output in_ready, out_valid, out_data, out_last, out_idx, argmax_idx, argmax_valid
    );
endinterface

// File: rtl/ternary_argmax_head.sv
// Classifier head behind the ternary matrix-vector multiplier.
// Collects OUT_LEN signed elements (optional per-element ReLU), tracks the running
// argmax, then replays the buffered frame with the argmax index held alongside.
// Ports:
//   clk   : single clock, posedge
//   rst_n : synchronous active-low reset
//   bus   : ternary_argmax_head_if.slave (input stream, output stream, argmax)
module ternary_argmax_head #(
    parameter int unsigned OUT_LEN   = 8,
    parameter int unsigned BIT_WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    ternary_argmax_head_if.slave bus
);
    localparam int unsigned      IDX_W    = $clog2(OUT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_LEN - 1);

    typedef enum logic {StCollect, StDrain} state_e;

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]            rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]            argmax_q, argmax_d;
    logic signed [BIT_WIDTH-1:0] max_val_q, max_val_d;
    logic                        argmax_valid_q, argmax_valid_d;
    logic [BIT_WIDTH-1:0]        buf_q [OUT_LEN];
    logic [BIT_WIDTH-1:0]        buf_d [OUT_LEN];

    logic                        in_ready;
    logic                        out_valid;
    logic                        accept;
    logic                        transfer;
    logic signed [BIT_WIDTH-1:0] store_val;

    // Outputs decode registered state only; rst_n gating keeps in_ready low in reset.
    always_comb begin
        in_ready         = rst_n && (state_q == StCollect);
        out_valid        = (state_q == StDrain);
        bus.in_ready     = in_ready;
        bus.out_valid    = out_valid;
        bus.out_data     = out_valid ? buf_q[rd_idx_q] : '0;
        bus.out_idx      = rd_idx_q;
        bus.out_last     = out_valid && (rd_idx_q == LAST_IDX);
        bus.argmax_idx   = argmax_q;
        bus.argmax_valid = argmax_valid_q;
    end

    always_comb begin
        accept    = bus.in_valid && in_ready;
        transfer  = out_valid && bus.out_ready;
        store_val = (bus.relu_en && bus.in_data[BIT_WIDTH-1]) ? '0 : $signed(bus.in_data);
    end

    always_comb begin
        state_d        = state_q;
        wr_idx_d       = wr_idx_q;
        rd_idx_d       = rd_idx_q;
        argmax_d       = argmax_q;
        max_val_d      = max_val_q;
        argmax_valid_d = argmax_valid_q;
        buf_d          = buf_q;

        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    buf_d[wr_idx_q] = store_val;
                    wr_idx_d        = wr_idx_q + 1'b1;
                    // First element seeds the max; later ones replace it only when
                    // strictly greater so ties keep the lowest index.
                    if (wr_idx_q == '0) begin
                        max_val_d = store_val;
                        argmax_d  = '0;
                    end else if (store_val > max_val_q) begin
                        max_val_d = store_val;
                        argmax_d  = wr_idx_q;
                    end
                    if (wr_idx_q == LAST_IDX) begin
                        state_d        = StDrain;
                        argmax_valid_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (transfer) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (rd_idx_q == LAST_IDX) begin
                        state_d        = StCollect;
                        argmax_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StCollect;
            wr_idx_q       <= '0;
            rd_idx_q       <= '0;
            argmax_q       <= '0;
            max_val_q      <= '0;
            argmax_valid_q <= 1'b0;
            buf_q          <= '{default: '0};
        end else begin
            state_q        <= state_d;
            wr_idx_q       <= wr_idx_d;
            rd_idx_q       <= rd_idx_d;
            argmax_q       <= argmax_d;
            max_val_q      <= max_val_d;
            argmax_valid_q <= argmax_valid_d;
            buf_q          <= buf_d;
        end
    end
endmodule

// File: tb/tb_ternary_argmax_head.sv
// Self-checking bench for ternary_argmax_head: queue-based frame model checked
// every cycle, directed frames pinned with literal expectations, then random traffic.
module tb_ternary_argmax_head;
    localparam int unsigned OUT_LEN   = 8;
    localparam int unsigned BIT_WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ternary_argmax_head_if #(.OUT_LEN(OUT_LEN), .BIT_WIDTH(BIT_WIDTH)) bus ();

    ternary_argmax_head #(.OUT_LEN(OUT_LEN), .BIT_WIDTH(BIT_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model: elements of the frame being collected, and the frame awaiting drain.
    int col_q[$];
    int drn_q[$];
    int m_arg = 0;

    // Observed drained data for the literal expectations.
    int got_q[$];
    int av_cycles;
    int got_arg;

    int stim_vals[OUT_LEN];
    bit stim_relu[OUT_LEN];
    int exp_vals[OUT_LEN];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge.
    always @(posedge clk) begin
        int v;
        if (!rst_n) begin
            col_q.delete();
            drn_q.delete();
            m_arg = 0;
        end else if (drn_q.size() > 0) begin
            if (bus.out_ready) void'(drn_q.pop_front());
        end else if (bus.in_valid) begin
            v = int'($signed(bus.in_data));
            if (bus.relu_en && v < 0) v = 0;
            col_q.push_back(v);
            m_arg = 0;
            for (int i = 1; i < col_q.size(); i++)
                if (col_q[i] > col_q[m_arg]) m_arg = i;
            if (col_q.size() == int'(OUT_LEN)) begin
                drn_q = col_q;
                col_q.delete();
            end
        end
    end

    // Record what actually left the block.
    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back(int'($signed(bus.out_data)));
        if (rst_n && bus.argmax_valid) begin
            av_cycles++;
            got_arg = int'(bus.argmax_idx);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int n;
        if (chk_en) begin
            n = drn_q.size();
            chk("in_ready", int'(bus.in_ready), (rst_n && n == 0) ? 1 : 0);
            chk("out_valid", int'(bus.out_valid), (n > 0) ? 1 : 0);
            if (n > 0) begin
                chk("out_data", int'($signed(bus.out_data)), drn_q[0]);
                chk("out_idx", int'(bus.out_idx), int'(OUT_LEN) - n);
            end else begin
                chk("out_data_idle", int'($signed(bus.out_data)), 0);
                chk("out_idx_idle", int'(bus.out_idx), 0);
            end
            chk("out_last", int'(bus.out_last), (n == 1) ? 1 : 0);
            chk("argmax_valid", int'(bus.argmax_valid), (n > 0) ? 1 : 0);
            chk("argmax_idx", int'(bus.argmax_idx), m_arg);
        end
    end

    // Entered and left at posedge+1 with the block idle in collect.
    task automatic run_frame(input int ready_mode, input bit hold_valid);
        int k;
        got_q.delete();
        av_cycles = 0;
        got_arg   = -1;
        for (int i = 0; i < int'(OUT_LEN); i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = BIT_WIDTH'(stim_vals[i]);
            bus.relu_en   = stim_relu[i];
            bus.out_ready = 1'($urandom_range(1));
            @(posedge clk);
            #1;
        end
        bus.in_valid = hold_valid;
        bus.in_data  = BIT_WIDTH'($urandom);
        k = 0;
        while (drn_q.size() > 0 && k < 64) begin
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (k % 3 == 0);
                default: bus.out_ready = 1'($urandom_range(1));
            endcase
            @(posedge clk);
            #1;
            k++;
        end
        if (drn_q.size() > 0) chk("drain_timeout", drn_q.size(), 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_frame(input string name, input int exp_arg);
        chk({name, "_count"}, got_q.size(), int'(OUT_LEN));
        for (int i = 0; i < int'(OUT_LEN) && i < got_q.size(); i++)
            chk({name, "_data"}, got_q[i], exp_vals[i]);
        chk({name, "_argmax"}, got_arg, exp_arg);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.relu_en   = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_argmax_valid", int'(bus.argmax_valid), 0);
        chk("rst_argmax_idx", int'(bus.argmax_idx), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", int'(bus.in_ready), 1);

        // ReLU off, no stalls.
        stim_vals = '{3, -5, 7, 7, -128, 0, 127, 2};
        stim_relu = '{default: 1'b0};
        exp_vals  = '{3, -5, 7, 7, -128, 0, 127, 2};
        run_frame(0, 1'b0);
        check_frame("basic", 6);
        chk("basic_argmax_valid_cycles", av_cycles, 8);

        // ReLU on, all negative: all zero, tie resolves to index 0.
        stim_vals = '{-1, -2, -3, -4, -5, -6, -7, -128};
        stim_relu = '{default: 1'b1};
        exp_vals  = '{default: 0};
        run_frame(0, 1'b0);
        check_frame("relu_neg", 0);

        // Ties keep the lowest index.
        stim_vals = '{5, 9, 9, 1, 9, 0, 0, 0};
        stim_relu = '{default: 1'b0};
        exp_vals  = '{5, 9, 9, 1, 9, 0, 0, 0};
        run_frame(0, 1'b0);
        check_frame("tie", 1);

        // Backpressure 1,0,0,1,... with in_valid held high during drain.
        stim_vals = '{3, -5, 7, 7, -128, 0, 127, 2};
        exp_vals  = '{3, -5, 7, 7, -128, 0, 127, 2};
        run_frame(1, 1'b1);
        check_frame("backpressure", 6);

        // Mid-frame reset discards the partial frame.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = BIT_WIDTH'(100 + i);
            bus.relu_en  = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        stim_vals = '{8, 1, 2, 3, 4, 5, 6, 7};
        exp_vals  = '{8, 1, 2, 3, 4, 5, 6, 7};
        run_frame(2, 1'b0);
        check_frame("mid_reset", 0);

        // relu_en sampled per element.
        stim_vals = '{-4, -4, 0, 0, 0, 0, 0, 0};
        stim_relu = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_vals  = '{0, -4, 0, 0, 0, 0, 0, 0};
        run_frame(0, 1'b0);
        check_frame("relu_toggle", 0);

        // Random traffic with occasional resets, checked by the per-cycle model.
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_data   = BIT_WIDTH'($urandom);
            bus.relu_en   = 1'($urandom_range(1));
            bus.out_ready = ($urandom_range(2) != 0);
            rst_n         = ($urandom_range(299) != 0);
            @(posedge clk);
            #1;
        end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
